alu_result_accumulator: RTL and testbench

Downstream stage of the 4-bit ALU. It consumes the registered signed 5-bit ALU result C through a valid/ready handshake and keeps a saturating signed running sum over a batch of BATCH results. It presents the batch sum, a saturation flag and a sample count to the next consumer through a second valid/ready handshake. It also supports an early flush of a partial batch.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_result_accumulator_if.sv | 30 +++
 rtl/alu_result_accumulator_sat_add.sv | 30 +++
 rtl/alu_result_accumulator.sv | 115 +++++++++++
 tb/tb_alu_result_accumulator.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its downstream stages.
//   ALU_IN_W / ALU_OUT_W : operand width and registered result (C) width
//   alu_op_e             : ALU opcode encoding
//   acc_state_e          : result accumulator control states
package alu_pkg;

    localparam int ALU_IN_W  = 4;
    // One extra bit holds the carry/borrow of a 4-bit add or subtract.
    localparam int ALU_OUT_W = ALU_IN_W + 1;

    typedef enum logic [1:0] {
        ADD    = 2'b00,
        SUB    = 2'b01,
        INV    = 2'b10,
        RED_OR = 2'b11
    } alu_op_e;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/alu_result_accumulator_if.sv
// Handshake bundle between the ALU, the result accumulator and its consumer.
//   in_valid/in_data/in_ready : sample stream into the accumulator
//   flush                     : request emission of a partial batch
//   out_valid/out_ready       : batch result handshake
//   out_sum/out_sat/out_count : batch result payload
// The slave modport is the accumulator's view; master is the driver side.
interface alu_result_accumulator_if #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 8
);
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_sat;
    logic [7:0]       out_count;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_sat, out_count
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_sum, out_sat, out_count
    );
endinterface

// File: rtl/alu_result_accumulator_sat_add.sv
// sat_add: combinational signed adder that clamps to the W-bit signed range.
//   i_a, i_b : signed addends
//   o_sum    : clamped sum in [-2^(W-1), 2^(W-1)-1]
//   o_ovf    : high when the clamp engaged
module sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_ovf
);
    localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    logic [W:0] w_wide;
    logic       w_pos_ovf;
    logic       w_neg_ovf;

    // One guard bit: the top two bits disagree exactly when the true sum
    // falls outside the W-bit signed range.
    assign w_wide    = {i_a[W-1], i_a} + {i_b[W-1], i_b};
    assign w_pos_ovf = ~w_wide[W] &  w_wide[W-1];
    assign w_neg_ovf =  w_wide[W] & ~w_wide[W-1];

    assign o_ovf = w_pos_ovf | w_neg_ovf;
    assign o_sum = w_pos_ovf ? MAX_VAL :
                   w_neg_ovf ? MIN_VAL :
                   w_wide[W-1:0];
endmodule

// File: rtl/alu_result_accumulator.sv
// alu_result_accumulator: saturating running sum over batches of ALU results.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : slave side of alu_result_accumulator_if (sample in, batch out)
// A batch closes when BATCH samples are accepted, or early on flush when at
// least one sample is in it (a sample arriving with flush is included).
// The result is held until the consumer takes it; one bubble cycle follows.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACCUM | in_ready=1, summing accepted samples into acc/cnt/sat
// HOLD  | out_valid=1, batch result frozen until out_ready
module alu_result_accumulator
    import alu_pkg::*;
#(
    parameter int IN_W  = ALU_OUT_W,
    parameter int ACC_W = 8,
    parameter int BATCH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    alu_result_accumulator_if.slave     bus
);
    acc_state_e       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_sat;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_sum;
    logic             r_out_sat;
    logic [7:0]       r_out_count;

    logic             w_in_ready;
    logic             w_accept;
    logic [ACC_W-1:0] w_in_ext;
    logic [ACC_W-1:0] w_add_sum;
    logic             w_add_ovf;
    logic [ACC_W-1:0] w_acc_next;
    logic [7:0]       w_cnt_next;
    logic             w_sat_next;
    logic             w_batch_full;
    logic             w_emit;
    logic             w_release;

    assign w_in_ready = (r_state == ACCUM);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_in_ext   = {{(ACC_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};

    sat_add #(.W(ACC_W)) u_sat_add (
        .i_a   (r_acc),
        .i_b   (w_in_ext),
        .o_sum (w_add_sum),
        .o_ovf (w_add_ovf)
    );

    // Post-update values; these are what an emitted batch reports.
    assign w_acc_next = w_accept ? w_add_sum : r_acc;
    assign w_cnt_next = w_accept ? r_cnt + 8'd1 : r_cnt;
    assign w_sat_next = r_sat | (w_accept & w_add_ovf);

    assign w_batch_full = w_accept & (w_cnt_next == 8'(BATCH));
    // An empty flush (no stored sample and nothing arriving) is dropped.
    assign w_emit       = w_batch_full |
                          (bus.flush & ((r_cnt != 8'd0) | w_accept));
    assign w_release    = r_out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_sat   <= 1'b0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    r_acc <= w_acc_next;
                    r_cnt <= w_cnt_next;
                    r_sat <= w_sat_next;
                    if (w_emit) begin
                        r_state     <= HOLD;
                        r_out_valid <= 1'b1;
                        r_out_sum   <= w_acc_next;
                        r_out_sat   <= w_sat_next;
                        r_out_count <= w_cnt_next;
                    end
                end
                HOLD: begin
                    // Payload registers are left untouched so the consumer
                    // sees a stable result for as long as it stalls.
                    if (w_release) begin
                        r_state     <= ACCUM;
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_sat       <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ACCUM;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_sat   = r_out_sat;
    assign bus.out_count = r_out_count;
endmodule

// File: tb/tb_alu_result_accumulator.sv
module tb_alu_result_accumulator;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_result_accumulator_if #(.IN_W(5), .ACC_W(8)) ifc4 ();
    alu_result_accumulator_if #(.IN_W(5), .ACC_W(8)) ifc12 ();

    alu_result_accumulator #(.IN_W(5), .ACC_W(8), .BATCH(4)) dut4 (
        .clk(clk), .reset(reset), .bus(ifc4)
    );
    alu_result_accumulator #(.IN_W(5), .ACC_W(8), .BATCH(12)) dut12 (
        .clk(clk), .reset(reset), .bus(ifc12)
    );

    typedef struct {
        int sum;
        int sat;
        int cnt;
    } exp_t;

    typedef struct {
        int d[4];
        int n;
        bit fl;
        int hold;
        int e_sum;
        int e_sat;
        int e_cnt;
    } vec_t;

    exp_t q4[$];
    exp_t q12[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk_exp(input int s, input int st, input int c);
        exp_t e;
        e.sum = s; e.sat = st; e.cnt = c;
        return e;
    endfunction

    function automatic vec_t mk_vec(input int d0, input int d1, input int d2,
                                    input int d3, input int n, input bit fl,
                                    input int hold, input int s, input int st,
                                    input int c);
        vec_t v;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.n = n; v.fl = fl; v.hold = hold;
        v.e_sum = s; v.e_sat = st; v.e_cnt = c;
        return v;
    endfunction

    // Scoreboards: a result is compared at the negedge before the edge
    // that completes its output handshake.
    always @(negedge clk) begin
        if (!reset && ifc4.out_valid && ifc4.out_ready) begin
            if (q4.size() == 0) begin
                chk("dut4_unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("dut4_out_sum", int'($signed(ifc4.out_sum)), e.sum);
                chk("dut4_out_sat", int'(ifc4.out_sat), e.sat);
                chk("dut4_out_count", int'(ifc4.out_count), e.cnt);
            end
        end
        if (!reset && ifc12.out_valid && ifc12.out_ready) begin
            if (q12.size() == 0) begin
                chk("dut12_unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = q12.pop_front();
                chk("dut12_out_sum", int'($signed(ifc12.out_sum)), e.sum);
                chk("dut12_out_sat", int'(ifc12.out_sat), e.sat);
                chk("dut12_out_count", int'(ifc12.out_count), e.cnt);
            end
        end
    end

    task automatic feed12(input int v, input int e_sum, input int e_sat);
        q12.push_back(mk_exp(e_sum, e_sat, 12));
        for (int i = 0; i < 12; i++) begin
            ifc12.in_valid = 1'b1;
            ifc12.in_data  = 5'(v);
            step();
        end
        ifc12.in_valid = 1'b0;
        chk("dut12_out_valid_after_last", int'(ifc12.out_valid), 1);
        chk("dut12_in_ready_hold", int'(ifc12.in_ready), 0);
        step();
        chk("dut12_out_valid_released", int'(ifc12.out_valid), 0);
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = mk_vec( 14,  14,  14,  14, 4, 1'b0, 0,  56, 0, 4);
        tbl[1] = mk_vec(-16, -16,   5,   0, 4, 1'b0, 5, -27, 0, 4);
        tbl[2] = mk_vec(  7,  -3,   2,   0, 3, 1'b1, 0,   6, 0, 3);
        tbl[3] = mk_vec(  1,   2,   3,   4, 4, 1'b0, 0,  10, 0, 4);
        tbl[4] = mk_vec( -1,  -2,  -3,  -4, 4, 1'b0, 0, -10, 0, 4);

        ifc4.in_valid  = 1'b0; ifc4.in_data  = '0; ifc4.flush  = 1'b0; ifc4.out_ready  = 1'b1;
        ifc12.in_valid = 1'b0; ifc12.in_data = '0; ifc12.flush = 1'b0; ifc12.out_ready = 1'b1;

        #1;
        chk("rst_out_valid", int'(ifc4.out_valid), 0);
        chk("rst_out_sum", int'(ifc4.out_sum), 0);
        chk("rst_out_sat", int'(ifc4.out_sat), 0);
        chk("rst_out_count", int'(ifc4.out_count), 0);
        chk("rst_dut12_out_valid", int'(ifc12.out_valid), 0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_in_ready", int'(ifc4.in_ready), 1);

        for (int r = 0; r < 5; r++) begin
            q4.push_back(mk_exp(tbl[r].e_sum, tbl[r].e_sat, tbl[r].e_cnt));
            ifc4.out_ready = (tbl[r].hold == 0);
            for (int i = 0; i < tbl[r].n; i++) begin
                ifc4.in_valid = 1'b1;
                ifc4.in_data  = 5'(tbl[r].d[i]);
                ifc4.flush    = tbl[r].fl && (i == tbl[r].n - 1);
                chk("in_ready_accum", int'(ifc4.in_ready), 1);
                step();
            end
            ifc4.in_valid = 1'b0;
            ifc4.flush    = 1'b0;
            chk("out_valid_after_last", int'(ifc4.out_valid), 1);
            chk("in_ready_bubble", int'(ifc4.in_ready), 0);
            if (tbl[r].hold > 0) begin
                for (int h = 0; h < tbl[r].hold; h++) begin
                    ifc4.in_valid = 1'b1;
                    ifc4.in_data  = 5'd9;
                    step();
                    chk("hold_out_valid", int'(ifc4.out_valid), 1);
                    chk("hold_out_sum", int'($signed(ifc4.out_sum)), tbl[r].e_sum);
                    chk("hold_out_count", int'(ifc4.out_count), tbl[r].e_cnt);
                    chk("hold_in_ready", int'(ifc4.in_ready), 0);
                end
                ifc4.in_valid  = 1'b0;
                ifc4.out_ready = 1'b1;
            end
            step();
            chk("out_valid_released", int'(ifc4.out_valid), 0);
            chk("in_ready_restored", int'(ifc4.in_ready), 1);
        end

        // Empty flush must not produce an output.
        ifc4.flush = 1'b1;
        step();
        ifc4.flush = 1'b0;
        chk("empty_flush_out_valid", int'(ifc4.out_valid), 0);
        step();
        chk("empty_flush_out_valid_late", int'(ifc4.out_valid), 0);

        // Async reset mid-batch after two accepted samples.
        ifc4.in_valid = 1'b1;
        ifc4.in_data  = 5'd1;
        step();
        step();
        ifc4.in_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("midbatch_rst_out_valid", int'(ifc4.out_valid), 0);
        chk("midbatch_rst_in_ready", int'(ifc4.in_ready), 1);
        #2 reset = 1'b0;
        step();

        // Async reset while holding an unconsumed result.
        ifc4.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifc4.in_valid = 1'b1;
            ifc4.in_data  = 5'd3;
            step();
        end
        ifc4.in_valid = 1'b0;
        chk("pre_rst_hold_out_valid", int'(ifc4.out_valid), 1);
        #3 reset = 1'b1;
        #1;
        chk("hold_rst_out_valid", int'(ifc4.out_valid), 0);
        chk("hold_rst_out_sum", int'(ifc4.out_sum), 0);
        chk("hold_rst_out_count", int'(ifc4.out_count), 0);
        chk("hold_rst_in_ready", int'(ifc4.in_ready), 1);
        #2 reset = 1'b0;
        step();

        ifc4.out_ready = 1'b1;
        q4.push_back(mk_exp(4, 0, 4));
        for (int i = 0; i < 4; i++) begin
            ifc4.in_valid = 1'b1;
            ifc4.in_data  = 5'd1;
            step();
        end
        ifc4.in_valid = 1'b0;
        chk("post_rst_out_valid", int'(ifc4.out_valid), 1);
        step();
        chk("post_rst_released", int'(ifc4.out_valid), 0);

        // Saturation with a 12-sample batch, then a clean batch to show
        // the sticky flag does not leak across batches.
        feed12(14, 127, 1);
        feed12(-16, -128, 1);
        feed12(1, 12, 0);

        step();
        chk("q4_drained", q4.size(), 0);
        chk("q12_drained", q12.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
